// File: rtl/dryer_pkg.sv
// Shared dryer definitions: state encoding, dial and heat codes, program table.
// The COOL state only exists when DRYER_COOLDOWN_EN is defined.
package dryer_pkg;

`ifdef DRYER_COOLDOWN_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_COOL   = 2'd3
  } dryer_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } dryer_state_e;
`endif

  localparam logic [3:0] DIAL_STANDARD   = 4'h1;
  localparam logic [3:0] DIAL_TOWELS     = 4'h2;
  localparam logic [3:0] DIAL_DELICATES  = 4'h4;
  localparam logic [3:0] DIAL_TOUCHUP    = 4'h8;
  localparam logic [3:0] DIAL_MANUAL_MIN = 4'hA;

  localparam logic [1:0] HEAT_OFF  = 2'b00;
  localparam logic [1:0] HEAT_LOW  = 2'b01;
  localparam logic [1:0] HEAT_MED  = 2'b10;
  localparam logic [1:0] HEAT_HIGH = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [3:0] phases;
    logic [1:0] heat;
  } prog_t;

  // Manual codes Ah..Fh map to 1..6 phases at the heat dial setting.
  function automatic prog_t decode_prog(input logic [3:0] dial, input logic [1:0] heat_dial);
    prog_t p;
    p = '{valid: 1'b0, phases: 4'd0, heat: HEAT_OFF};
    case (dial)
      DIAL_STANDARD:  p = '{valid: 1'b1, phases: 4'd5, heat: HEAT_LOW};
      DIAL_TOWELS:    p = '{valid: 1'b1, phases: 4'd5, heat: HEAT_HIGH};
      DIAL_DELICATES: p = '{valid: 1'b1, phases: 4'd2, heat: HEAT_OFF};
      DIAL_TOUCHUP:   p = '{valid: 1'b1, phases: 4'd1, heat: HEAT_LOW};
      default: begin
        if (dial >= DIAL_MANUAL_MIN)
          p = '{valid: 1'b1, phases: dial - 4'd9, heat: heat_dial};
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dryer_timebase.sv
// Prescaler plus seconds counter; pulse is high for the one cycle that completes
// the programmed number of seconds.
module dryer_timebase #(
  parameter int CLK_HZ = 50000,
  parameter int SEC_W  = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             clear,
  input  logic [SEC_W-1:0] limit,
  output logic             pulse
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PRE_W-1:0] presc;
  logic [SEC_W-1:0] secs;
  logic             tick;

  assign tick  = enable && (presc == PRE_W'(CLK_HZ - 1));
  assign pulse = tick && (secs == (limit - SEC_W'(1)));

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      presc <= '0;
      secs  <= '0;
    end else if (enable) begin
      if (tick) begin
        presc <= '0;
        secs  <= pulse ? '0 : secs + SEC_W'(1);
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/dryer_seq_ctrl.sv
// Dryer cycle sequencer: program decode, phase countdown, pause/resume and
// optional cool-down (built only when DRYER_COOLDOWN_EN is defined).
module dryer_seq_ctrl
  import dryer_pkg::*;
#(
  parameter int CLK_HZ    = 50000,
  parameter int PHASE_SEC = 900,
  parameter int COOL_SEC  = 300,
  parameter int PH_W      = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ON,
  input  logic            OFF,
  input  logic            PAUSE,
  input  logic            DOOR_OPEN,
  input  logic [3:0]      mainDial,
  input  logic [1:0]      heatDial,
  output logic            MTR,
  output logic [1:0]      HTR,
  output logic            BUSY,
  output logic [PH_W-1:0] PHASES_LEFT,
  output logic            DONE
);

`ifdef DRYER_COOLDOWN_EN
  localparam int SEC_MAX = (COOL_SEC > PHASE_SEC) ? COOL_SEC : PHASE_SEC;
`else
  localparam int SEC_MAX = PHASE_SEC;
`endif
  localparam int SEC_W = $clog2(SEC_MAX + 1);

  dryer_state_e     state;
  logic [1:0]       heat_lvl;
  prog_t            prog;
  logic             start_ok;
  logic             tb_en;
  logic             tb_clr;
  logic             phase_end;
  logic [SEC_W-1:0] limit;

  assign prog     = decode_prog(mainDial, heatDial);
  assign start_ok = ON && prog.valid && !OFF && !DOOR_OPEN && !PAUSE;

  // Timers only advance in a cycle that is not being preempted by a stop,
  // pause or restart, so no counts are lost across a pause.
  always_comb begin
    tb_en  = 1'b0;
    tb_clr = (state == ST_IDLE) || OFF;
    limit  = SEC_W'(PHASE_SEC);
    case (state)
      ST_RUN: begin
        if (start_ok) tb_clr = 1'b1;
        else          tb_en  = !OFF && !DOOR_OPEN && !PAUSE;
      end
`ifdef DRYER_COOLDOWN_EN
      ST_COOL: begin
        tb_en = !OFF && !DOOR_OPEN;
        limit = SEC_W'(COOL_SEC);
      end
`endif
      default: ;
    endcase
  end

  dryer_timebase #(
    .CLK_HZ (CLK_HZ),
    .SEC_W  (SEC_W)
  ) u_timebase (
    .CLK    (CLK),
    .RESET  (RESET),
    .enable (tb_en),
    .clear  (tb_clr),
    .limit  (limit),
    .pulse  (phase_end)
  );

  // Outputs are set together with the state so they never lag it.
  task automatic go(input dryer_state_e s, input logic [1:0] h);
    state <= s;
    BUSY  <= (s != ST_IDLE);
`ifdef DRYER_COOLDOWN_EN
    MTR   <= (s == ST_RUN) || (s == ST_COOL);
`else
    MTR   <= (s == ST_RUN);
`endif
    HTR   <= (s == ST_RUN) ? h : HEAT_OFF;
  endtask

  always_ff @(posedge CLK) begin
    if (RESET) begin
      go(ST_IDLE, HEAT_OFF);
      heat_lvl    <= HEAT_OFF;
      PHASES_LEFT <= '0;
      DONE        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (OFF) begin
        go(ST_IDLE, HEAT_OFF);
        PHASES_LEFT <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              go(ST_RUN, prog.heat);
              heat_lvl    <= prog.heat;
              PHASES_LEFT <= PH_W'(prog.phases);
            end
          end
          ST_RUN: begin
            if (DOOR_OPEN || PAUSE) begin
              go(ST_PAUSED, HEAT_OFF);
            end else if (start_ok) begin
              go(ST_RUN, prog.heat);
              heat_lvl    <= prog.heat;
              PHASES_LEFT <= PH_W'(prog.phases);
            end else if (phase_end) begin
              if (PHASES_LEFT <= PH_W'(1)) begin
                PHASES_LEFT <= '0;
`ifdef DRYER_COOLDOWN_EN
                go(ST_COOL, HEAT_OFF);
`else
                go(ST_IDLE, HEAT_OFF);
                DONE <= 1'b1;
`endif
              end else begin
                PHASES_LEFT <= PHASES_LEFT - PH_W'(1);
              end
            end
          end
          ST_PAUSED: begin
            if (ON && !DOOR_OPEN && !PAUSE)
              go(ST_RUN, heat_lvl);
          end
`ifdef DRYER_COOLDOWN_EN
          ST_COOL: begin
            if (DOOR_OPEN) begin
              go(ST_IDLE, HEAT_OFF);
            end else if (phase_end) begin
              go(ST_IDLE, HEAT_OFF);
              DONE <= 1'b1;
            end
          end
`endif
          default: begin
            go(ST_IDLE, HEAT_OFF);
            PHASES_LEFT <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dryer_seq_ctrl.sv
// Directed bench for dryer_seq_ctrl (CLK_HZ=4, PHASE_SEC=2, COOL_SEC=1):
// one phase is 8 cycles, cool-down is 4 cycles. Honours DRYER_COOLDOWN_EN.
module tb_dryer_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, ON, OFF, PAUSE, DOOR_OPEN;
  logic [3:0] mainDial;
  logic [1:0] heatDial;
  logic       MTR, BUSY, DONE;
  logic [1:0] HTR;
  logic [3:0] PHASES_LEFT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst, on, off, pause, door;
    logic [3:0] dial;
    logic [1:0] heat;
    logic       mtr;
    logic [1:0] htr;
    logic       busy;
    logic [3:0] ph;
    logic       done;
  } vec_t;

  vec_t vecs[20];

  dryer_seq_ctrl #(
    .CLK_HZ    (4),
    .PHASE_SEC (2),
    .COOL_SEC  (1),
    .PH_W      (4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ON          (ON),
    .OFF         (OFF),
    .PAUSE       (PAUSE),
    .DOOR_OPEN   (DOOR_OPEN),
    .mainDial    (mainDial),
    .heatDial    (heatDial),
    .MTR         (MTR),
    .HTR         (HTR),
    .BUSY        (BUSY),
    .PHASES_LEFT (PHASES_LEFT),
    .DONE        (DONE)
  );

  always #5 CLK = ~CLK;

  // Drives inputs, then lets one rising edge happen and settles 1 time unit past it.
  task automatic applyStimulus(input logic rst, input logic on, input logic off,
                               input logic pause, input logic door,
                               input logic [3:0] dial, input logic [1:0] heat);
    RESET     = rst;
    ON        = on;
    OFF       = off;
    PAUSE     = pause;
    DOOR_OPEN = door;
    mainDial  = dial;
    heatDial  = heat;
    @(posedge CLK);
    #1;
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mainDial, heatDial);
  endtask

  task automatic checkOutput(input string name, input logic mtr, input logic [1:0] htr,
                             input logic busy, input logic [3:0] ph, input logic done);
    total++;
    if ({MTR, HTR, BUSY, PHASES_LEFT, DONE} !== {mtr, htr, busy, ph, done}) begin
      bad++;
      $display("[TB] FAIL %s: got mtr=%0b htr=%0b busy=%0b ph=%0d done=%0b, want mtr=%0b htr=%0b busy=%0b ph=%0d done=%0b",
               name, MTR, HTR, BUSY, PHASES_LEFT, DONE, mtr, htr, busy, ph, done);
    end
  endtask

  initial begin
    //          rst on off pse door dial   heat | mtr htr   busy ph     done
    vecs[0]  = '{1, 0, 0, 0, 0, 4'h0, 2'd0, 0, 2'd0, 0, 4'd0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 4'h3, 2'd0, 0, 2'd0, 0, 4'd0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 4'hC, 2'd2, 1, 2'd2, 1, 4'd3, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 4'hC, 2'd2, 1, 2'd2, 1, 4'd3, 0};
    vecs[4]  = '{0, 1, 1, 0, 0, 4'hC, 2'd2, 0, 2'd0, 0, 4'd0, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 4'h2, 2'd0, 1, 2'd3, 1, 4'd5, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 4'h2, 2'd0, 0, 2'd0, 1, 4'd5, 0};
    vecs[7]  = '{0, 1, 0, 1, 0, 4'h2, 2'd0, 0, 2'd0, 1, 4'd5, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 4'h2, 2'd0, 1, 2'd3, 1, 4'd5, 0};
    vecs[9]  = '{0, 1, 0, 0, 1, 4'h2, 2'd0, 0, 2'd0, 1, 4'd5, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 4'h2, 2'd0, 0, 2'd0, 0, 4'd0, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 4'h1, 2'd0, 1, 2'd1, 1, 4'd5, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 4'hF, 2'd1, 1, 2'd1, 1, 4'd6, 0};
    vecs[13] = '{0, 1, 0, 0, 0, 4'hA, 2'd3, 1, 2'd3, 1, 4'd1, 0};
    vecs[14] = '{0, 1, 0, 0, 0, 4'h5, 2'd0, 1, 2'd3, 1, 4'd1, 0};
    vecs[15] = '{0, 0, 1, 0, 0, 4'h5, 2'd0, 0, 2'd0, 0, 4'd0, 0};
    vecs[16] = '{0, 1, 0, 0, 1, 4'h1, 2'd0, 0, 2'd0, 0, 4'd0, 0};
    vecs[17] = '{0, 1, 0, 0, 0, 4'h8, 2'd0, 1, 2'd1, 1, 4'd1, 0};
    vecs[18] = '{0, 0, 0, 0, 0, 4'h8, 2'd0, 1, 2'd1, 1, 4'd1, 0};
    vecs[19] = '{1, 0, 0, 0, 0, 4'h8, 2'd0, 0, 2'd0, 0, 4'd0, 0};

    RESET = 1'b1; ON = 1'b0; OFF = 1'b0; PAUSE = 1'b0; DOOR_OPEN = 1'b0;
    mainDial = 4'h0; heatDial = 2'd0;
    @(negedge CLK);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].on, vecs[i].off, vecs[i].pause, vecs[i].door,
                    vecs[i].dial, vecs[i].heat);
      checkOutput($sformatf("vec%0d", i), vecs[i].mtr, vecs[i].htr, vecs[i].busy,
                  vecs[i].ph, vecs[i].done);
    end

    // Delicates: two 8-cycle phases, then cool-down or direct finish.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 2'd3);
    checkOutput("dlc_start", 1, 2'd0, 1, 4'd2, 0);
    idleSteps(7);
    checkOutput("dlc_e7", 1, 2'd0, 1, 4'd2, 0);
    idleSteps(1);
    checkOutput("dlc_e8", 1, 2'd0, 1, 4'd1, 0);
    idleSteps(7);
    checkOutput("dlc_e15", 1, 2'd0, 1, 4'd1, 0);
    idleSteps(1);
`ifdef DRYER_COOLDOWN_EN
    checkOutput("dlc_cool", 1, 2'd0, 1, 4'd0, 0);
    idleSteps(3);
    checkOutput("dlc_cool_e19", 1, 2'd0, 1, 4'd0, 0);
    idleSteps(1);
    checkOutput("dlc_done", 0, 2'd0, 0, 4'd0, 1);
`else
    checkOutput("dlc_done", 0, 2'd0, 0, 4'd0, 1);
`endif
    idleSteps(1);
    checkOutput("dlc_done_clr", 0, 2'd0, 0, 4'd0, 0);

    // Door opened in the sixth RUN cycle; the phase must end 3 cycles after resume.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0);
    checkOutput("door_start", 1, 2'd1, 1, 4'd5, 0);
    idleSteps(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd0);
    checkOutput("door_pause", 0, 2'd0, 1, 4'd5, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 2'd0);
    checkOutput("door_on_open", 0, 2'd0, 1, 4'd5, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0);
    checkOutput("door_resume", 1, 2'd1, 1, 4'd5, 0);
    idleSteps(2);
    checkOutput("door_r2", 1, 2'd1, 1, 4'd5, 0);
    idleSteps(1);
    checkOutput("door_r3", 1, 2'd1, 1, 4'd4, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 2'd0);
    checkOutput("door_off", 0, 2'd0, 0, 4'd0, 0);

    // Touch-up: a single phase of 8 cycles.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 2'd0);
    idleSteps(7);
    checkOutput("tu_e7", 1, 2'd1, 1, 4'd1, 0);
    idleSteps(1);
`ifdef DRYER_COOLDOWN_EN
    checkOutput("tu_cool", 1, 2'd0, 1, 4'd0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 2'd0);
    checkOutput("tu_reset_cool", 0, 2'd0, 0, 4'd0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 2'd0);
    idleSteps(8);
    checkOutput("tu2_cool", 1, 2'd0, 1, 4'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 2'd0);
    checkOutput("tu2_door_cool", 0, 2'd0, 0, 4'd0, 0);
    idleSteps(4);
    checkOutput("tu2_no_done", 0, 2'd0, 0, 4'd0, 0);
`else
    checkOutput("tu_done", 0, 2'd0, 0, 4'd0, 1);
    idleSteps(1);
    checkOutput("tu_idle", 0, 2'd0, 0, 4'd0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
